// File: rtl/pss_pkg.sv
// Types and constants shared by the PSS detector and its tracking controller.
package pss_pkg;

  localparam int unsigned SSB_INTERVAL_DEFAULT = 38400;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    FIND   = 2'd1,
    PAUSE  = 2'd2
  } pss_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StPause,
    StFind
  } trk_state_t;

  // Detector mode presented while the controller sits in a given state.
  function automatic pss_mode_t state2mode(trk_state_t st);
    pss_mode_t m;
    m = PAUSE;
    unique case (st)
      StSearch: m = SEARCH;
      StFind:   m = FIND;
      default:  m = PAUSE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pss_track_ctrl_if.sv
// Detector-side bundle: sample strobe and detection results in, mode/request out.
interface pss_track_ctrl_if;
  import pss_pkg::*;

  logic      s_axis_in_tvalid;
  logic[1:0] N_id_2;
  logic      N_id_2_valid;
  pss_mode_t mode;
  logic[1:0] requested_N_id_2;

  modport master (
    input  s_axis_in_tvalid, N_id_2, N_id_2_valid,
    output mode, requested_N_id_2
  );

  modport slave (
    output s_axis_in_tvalid, N_id_2, N_id_2_valid,
    input  mode, requested_N_id_2
  );
endinterface

// File: rtl/ssb_window_timer.sv
// Sample counter since the last anchor, with compare strobes for the end of
// the PAUSE gap and the end of the FIND window.
module ssb_window_timer #(
  parameter int unsigned SSB_INTERVAL    = 38400,
  parameter int unsigned TRACK_TOLERANCE = 100,
  parameter int unsigned CNT_DW          = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              strobe_i,
  input  logic              count_en_i,
  input  logic              clr_i,
  input  logic              load_tol_i,
  output logic [CNT_DW-1:0] cnt_o,
  output logic              pause_end_o,
  output logic              find_end_o
);

  localparam logic [CNT_DW-1:0] PauseLast = CNT_DW'(SSB_INTERVAL - TRACK_TOLERANCE - 1);
  localparam logic [CNT_DW-1:0] FindLast  = CNT_DW'(SSB_INTERVAL + TRACK_TOLERANCE);
  localparam logic [CNT_DW-1:0] TolVal    = CNT_DW'(TRACK_TOLERANCE);

  logic [CNT_DW-1:0] cnt_q, cnt_d;
  logic              tick;

  assign tick = count_en_i & strobe_i;

  // Clear/load take priority over the strobe so an anchor never counts it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_tol_i) begin
      cnt_d = TolVal;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign pause_end_o = tick & (cnt_q == PauseLast);
  assign find_end_o  = tick & (cnt_q == FindLast);

endmodule

// File: rtl/pss_track_ctrl.sv
// PSS tracking controller: blind search, then PAUSE/FIND windows one SSB apart.
// Optional hit/drop statistics counters are built when PSS_TRACK_STATS_EN is defined.
module pss_track_ctrl
  import pss_pkg::*;
#(
  parameter int unsigned SSB_INTERVAL    = SSB_INTERVAL_DEFAULT,
  parameter int unsigned TRACK_TOLERANCE = 100,
  parameter int unsigned MAX_MISSES      = 3,
  parameter int unsigned CNT_DW          = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     enable_i,
  pss_track_ctrl_if.master         det_io,
`ifdef PSS_TRACK_STATS_EN
  output logic [15:0]              hit_cnt_o,
  output logic [15:0]              drop_cnt_o,
`endif
  output logic                     locked_o,
  output logic [1:0]               N_id_2_o,
  output logic signed [CNT_DW:0]   offset_o,
  output logic                     offset_valid_o
);

  if (TRACK_TOLERANCE >= SSB_INTERVAL / 2) begin : g_bad_tol
    $error("TRACK_TOLERANCE must be below SSB_INTERVAL/2");
  end
  if (MAX_MISSES < 1) begin : g_bad_miss
    $error("MAX_MISSES must be at least 1");
  end

  localparam int unsigned MissW = $clog2(MAX_MISSES + 1);
  localparam logic [CNT_DW:0] SsbWide = (CNT_DW + 1)'(SSB_INTERVAL);

  trk_state_t        state_q, state_d;
  logic [MissW-1:0]  miss_q, miss_d;
  pss_mode_t         mode_q;
  logic [1:0]        nid_q, nid_d;
  logic              locked_q, locked_d;
  logic [CNT_DW:0]   offset_q, offset_d;
  logic              ov_q, ov_d;
  logic              cnt_clr, cnt_load_tol, count_en, hit, drop;
  logic              pause_end, find_end;
  logic [CNT_DW-1:0] cnt;

  assign hit      = det_io.N_id_2_valid;
  assign count_en = (state_q == StPause) || (state_q == StFind);

  ssb_window_timer #(
    .SSB_INTERVAL    (SSB_INTERVAL),
    .TRACK_TOLERANCE (TRACK_TOLERANCE),
    .CNT_DW          (CNT_DW)
  ) u_timer (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .strobe_i    (det_io.s_axis_in_tvalid),
    .count_en_i  (count_en),
    .clr_i       (cnt_clr),
    .load_tol_i  (cnt_load_tol),
    .cnt_o       (cnt),
    .pause_end_o (pause_end),
    .find_end_o  (find_end)
  );

  always_comb begin
    state_d      = state_q;
    miss_d       = miss_q;
    nid_d        = nid_q;
    locked_d     = locked_q;
    offset_d     = offset_q;
    ov_d         = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load_tol = 1'b0;
    drop         = 1'b0;
    if (!enable_i) begin
      state_d  = StIdle;
      miss_d   = '0;
      locked_d = 1'b0;
      cnt_clr  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          miss_d  = '0;
          cnt_clr = 1'b1;
          state_d = StSearch;
        end
        StSearch: begin
          if (hit) begin
            nid_d   = det_io.N_id_2;
            cnt_clr = 1'b1;
            state_d = StPause;
          end
        end
        StPause: begin
          if (pause_end) state_d = StFind;
        end
        StFind: begin
          // A hit on the expiry strobe still counts as a hit.
          if (hit) begin
            offset_d = {1'b0, cnt} - SsbWide;
            ov_d     = 1'b1;
            locked_d = 1'b1;
            miss_d   = '0;
            cnt_clr  = 1'b1;
            state_d  = StPause;
          end else if (find_end) begin
            if ((32'(miss_q) + 32'd1) == MAX_MISSES) begin
              drop     = 1'b1;
              locked_d = 1'b0;
              miss_d   = '0;
              state_d  = StSearch;
            end else begin
              miss_d       = miss_q + 1'b1;
              cnt_load_tol = 1'b1;
              state_d      = StPause;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      miss_q   <= '0;
      mode_q   <= PAUSE;
      nid_q    <= '0;
      locked_q <= 1'b0;
      offset_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      mode_q   <= state2mode(state_d);
      nid_q    <= nid_d;
      locked_q <= locked_d;
      offset_q <= offset_d;
      ov_q     <= ov_d;
    end
  end

`ifdef PSS_TRACK_STATS_EN
  logic [15:0] hit_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hit_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (ov_d && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

  assign det_io.mode             = mode_q;
  assign det_io.requested_N_id_2 = nid_q;
  assign locked_o                = locked_q;
  assign N_id_2_o                = nid_q;
  assign offset_o                = offset_q;
  assign offset_valid_o          = ov_q;

endmodule

// File: tb/tb_pss_track_ctrl.sv
// Directed vector bench for pss_track_ctrl (SSB 1000, tolerance 10, 3 misses).
module tb_pss_track_ctrl;
  import pss_pkg::*;

  localparam int unsigned Ssb = 1000;
  localparam int unsigned Tol = 10;
  localparam int unsigned Dw  = $clog2(Ssb + Tol + 1);

  typedef struct {
    string name;
    int    cyc;
    bit    en;
    bit    vld;
    int    nid_in;
    int    mode;
    int    nid;
    int    lk;
    int    off;
    int    ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic locked;
  logic [1:0] nid_o;
  logic signed [Dw:0] offset;
  logic offset_valid;
`ifdef PSS_TRACK_STATS_EN
  logic [15:0] hit_cnt, drop_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[$];

  pss_track_ctrl_if det_if();

  pss_track_ctrl #(
    .SSB_INTERVAL    (Ssb),
    .TRACK_TOLERANCE (Tol),
    .MAX_MISSES      (3),
    .CNT_DW          (Dw)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .enable_i       (en),
    .det_io         (det_if),
`ifdef PSS_TRACK_STATS_EN
    .hit_cnt_o      (hit_cnt),
    .drop_cnt_o     (drop_cnt),
`endif
    .locked_o       (locked),
    .N_id_2_o       (nid_o),
    .offset_o       (offset),
    .offset_valid_o (offset_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string n, int cyc, bit e, bit v, int ni, int m, int nd, int lk,
                              int off, int ov);
    vec_t r;
    r.name = n; r.cyc = cyc; r.en = e; r.vld = v; r.nid_in = ni;
    r.mode = m; r.nid = nd; r.lk = lk; r.off = off; r.ov = ov;
    return r;
  endfunction

  task automatic check_outs(input string n, input int m, input int nd, input int lk,
                            input int off, input int ov);
    check({n, "_mode"}, int'(det_if.mode), m);
    check({n, "_nid"}, int'(nid_o), nd);
    check({n, "_req"}, int'(det_if.requested_N_id_2), nd);
    check({n, "_lock"}, int'(locked), lk);
    check({n, "_off"}, int'(offset), off);
    check({n, "_ov"}, int'(offset_valid), ov);
  endtask

  initial begin
    // mode: SEARCH=0 FIND=1 PAUSE=2; all rows keep the sample strobe high
    vecs.push_back(mk("idle2search",  1, 1, 0, 0, 0, 0, 0,   0, 0));
    vecs.push_back(mk("search_hit",   1, 1, 1, 2, 2, 2, 0,   0, 0));
    vecs.push_back(mk("pause_989",  989, 1, 0, 2, 2, 2, 0,   0, 0));
    vecs.push_back(mk("find_990",     1, 1, 0, 2, 1, 2, 0,   0, 0));
    vecs.push_back(mk("find_1003",   13, 1, 0, 2, 1, 2, 0,   0, 0));
    vecs.push_back(mk("hit_p3",       1, 1, 1, 2, 2, 2, 1,   3, 1));
    vecs.push_back(mk("ov_clear",     1, 1, 0, 2, 2, 2, 1,   3, 0));
    vecs.push_back(mk("pause2",     988, 1, 0, 2, 2, 2, 1,   3, 0));
    vecs.push_back(mk("find2",        1, 1, 0, 2, 1, 2, 1,   3, 0));
    vecs.push_back(mk("find2_995",    5, 1, 0, 2, 1, 2, 1,   3, 0));
    vecs.push_back(mk("hit_m5",       1, 1, 1, 2, 2, 2, 1,  -5, 1));
    vecs.push_back(mk("pause3",     989, 1, 0, 2, 2, 2, 1,  -5, 0));
    vecs.push_back(mk("find3",        1, 1, 0, 2, 1, 2, 1,  -5, 0));
    vecs.push_back(mk("find3_1010",  20, 1, 0, 2, 1, 2, 1,  -5, 0));
    vecs.push_back(mk("hit_edge",     1, 1, 1, 2, 2, 2, 1,  10, 1));
    vecs.push_back(mk("find4",      990, 1, 0, 2, 1, 2, 1,  10, 0));
    vecs.push_back(mk("find4_1010",  20, 1, 0, 2, 1, 2, 1,  10, 0));
    vecs.push_back(mk("miss1",        1, 1, 0, 2, 2, 2, 1,  10, 0));
    vecs.push_back(mk("m1_pause",   979, 1, 0, 2, 2, 2, 1,  10, 0));
    vecs.push_back(mk("m1_find",      1, 1, 0, 2, 1, 2, 1,  10, 0));
    vecs.push_back(mk("miss2",       21, 1, 0, 2, 2, 2, 1,  10, 0));
    vecs.push_back(mk("m2_find",    980, 1, 0, 2, 1, 2, 1,  10, 0));
    vecs.push_back(mk("m2_994",       4, 1, 0, 2, 1, 2, 1,  10, 0));
    vecs.push_back(mk("hit_m6",       1, 1, 1, 2, 2, 2, 1,  -6, 1));
    vecs.push_back(mk("l_find1",    990, 1, 0, 2, 1, 2, 1,  -6, 0));
    vecs.push_back(mk("l_miss1",     21, 1, 0, 2, 2, 2, 1,  -6, 0));
    vecs.push_back(mk("l_find2",    980, 1, 0, 2, 1, 2, 1,  -6, 0));
    vecs.push_back(mk("l_miss2",     21, 1, 0, 2, 2, 2, 1,  -6, 0));
    vecs.push_back(mk("l_find3",    980, 1, 0, 2, 1, 2, 1,  -6, 0));
    vecs.push_back(mk("lock_lost",   21, 1, 0, 2, 0, 2, 0,  -6, 0));
    vecs.push_back(mk("research",     5, 1, 0, 2, 0, 2, 0,  -6, 0));
    vecs.push_back(mk("search_hit1",  1, 1, 1, 1, 2, 1, 0,  -6, 0));
    vecs.push_back(mk("pause5",     989, 1, 0, 1, 2, 1, 0,  -6, 0));
    vecs.push_back(mk("find5",        1, 1, 0, 1, 1, 1, 0,  -6, 0));
    vecs.push_back(mk("hit_m10",      1, 1, 1, 1, 2, 1, 1, -10, 1));
    vecs.push_back(mk("find6",      990, 1, 0, 1, 1, 1, 1, -10, 0));
    vecs.push_back(mk("disable",      1, 0, 0, 1, 2, 1, 0, -10, 0));
    vecs.push_back(mk("idle_hold",    3, 0, 0, 1, 2, 1, 0, -10, 0));

    det_if.s_axis_in_tvalid = 1'b0;
    det_if.N_id_2 = 2'd0;
    det_if.N_id_2_valid = 1'b0;
    step();
    step();
    check_outs("reset", 2, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[k]) begin
      en = vecs[k].en;
      det_if.s_axis_in_tvalid = 1'b1;
      det_if.N_id_2_valid = vecs[k].vld;
      det_if.N_id_2 = 2'(vecs[k].nid_in);
      for (int i = 0; i < vecs[k].cyc; i++) step();
      check_outs(vecs[k].name, vecs[k].mode, vecs[k].nid, vecs[k].lk, vecs[k].off, vecs[k].ov);
    end
    det_if.N_id_2_valid = 1'b0;

    // Strobes at 50% duty: the window opens after 990 strobes, not 990 cycles.
    en = 1'b1;
    det_if.s_axis_in_tvalid = 1'b0;
    step();
    check("gap_search", int'(det_if.mode), 0);
    det_if.N_id_2_valid = 1'b1;
    det_if.N_id_2 = 2'd3;
    step();
    det_if.N_id_2_valid = 1'b0;
    check("gap_anchor_nid", int'(nid_o), 3);
    for (int i = 0; i < 989; i++) begin
      det_if.s_axis_in_tvalid = 1'b1;
      step();
      det_if.s_axis_in_tvalid = 1'b0;
      step();
    end
    check("gap_pause_989", int'(det_if.mode), 2);
    det_if.s_axis_in_tvalid = 1'b1;
    step();
    check("gap_find_990", int'(det_if.mode), 1);

    det_if.N_id_2_valid = 1'b1;
    step();
    det_if.N_id_2_valid = 1'b0;
    check("gap_hit_lock", int'(locked), 1);
    check("gap_hit_off", int'(offset), -10);
    for (int i = 0; i < 990; i++) step();
    check("rst_pre_find", int'(det_if.mode), 1);
`ifdef PSS_TRACK_STATS_EN
    check("stat_hits", int'(hit_cnt), 6);
    check("stat_drops", int'(drop_cnt), 1);
`endif

    // Asynchronous reset in the middle of a FIND window.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2, 0, 0, 0, 0);
`ifdef PSS_TRACK_STATS_EN
    check("stat_hits_rst", int'(hit_cnt), 0);
    check("stat_drops_rst", int'(drop_cnt), 0);
`endif
    step();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
